vga_display_core: RTL

//  Parametrised VGA display engine: pixel-tick divider, h/v timing counters, sync/blank generation,

---
 rtl/vga_display_core.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_display_core.sv
// vga_display_core: parametrised VGA display engine.
// Pixel-tick divider, h/v timing counters, sync/blank generation, a PIPE_LAT
// stage alignment line matching the external pixel source latency, and
// MSB-first replication of IN_BITS colour fields to 8-bit DAC channels.
// Optional feature macro: VGA_TEST_PATTERN_EN adds a test_mode input that
// replaces the pixel source with eight vertical colour bars, switched only
// at frame boundaries.
module vga_display_core #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int IN_BITS  = 1,
  parameter int PIPE_LAT = 1,
  parameter int CNT_W    = 10
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [3*IN_BITS-1:0] pix_rgb,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  output logic                 pix_en,
  output logic [CNT_W-1:0]     hcount,
  output logic [CNT_W-1:0]     vcount,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 bright,
  output logic                 frame_start,
  output logic [7:0]           Red,
  output logic [7:0]           Green,
  output logic [7:0]           Blue,
  output logic                 vga_clk
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
`ifdef VGA_TEST_PATTERN_EN
  localparam int DW       = 5 + CNT_W;
`else
  localparam int DW       = 4;
`endif

  // Replicate an IN_BITS field MSB-first across 8 bits (3'b101 -> 8'hB6).
  function automatic logic [7:0] expand(input logic [IN_BITS-1:0] ch);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < 8; i++) begin
      e[7-i] = ch[IN_BITS-1-(i % IN_BITS)];
    end
    return e;
  endfunction

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_next_s;
  logic             pix_en_r;
  logic             vga_clk_r;
  logic [CNT_W-1:0] hcount_r, vcount_r;
  logic [CNT_W-1:0] hcount_next_s, vcount_next_s;
  logic             hs_s, vs_s, act_s, sof_s;
  logic [DW-1:0]    raw_s, dly_s;
  logic             hs_d, vs_d, act_d, sof_d;
  logic             hsync_r, vsync_r, bright_r, frame_start_r;
  logic [7:0]       red_r, green_r, blue_r;
  logic [7:0]       red_s, green_s, blue_s;
`ifdef VGA_TEST_PATTERN_EN
  logic             mode_r, mode_s, mode_d;
  logic [CNT_W-1:0] hcount_d;
  logic [CNT_W+2:0] bar_prod_s;
  logic [2:0]       bar_idx_s;
`endif

  // Divider next value: count 0..CLK_DIV-1 and wrap.
  always_comb begin
    div_next_s = div_r;
    if (div_r == DIV_W'(CLK_DIV - 1)) begin
      div_next_s = {DIV_W{1'b0}};
    end else begin
      div_next_s = div_r + DIV_W'(1);
    end
  end

  // Divider state plus registered pixel tick and DAC clock decoded from the next count.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      div_r     <= {DIV_W{1'b0}};
      pix_en_r  <= 1'b0;
      vga_clk_r <= 1'b0;
    end else begin
      div_r     <= div_next_s;
      pix_en_r  <= (div_next_s == DIV_W'(CLK_DIV - 1));
      vga_clk_r <= (div_next_s >= DIV_W'(CLK_DIV / 2));
    end
  end

  // Horizontal/vertical position next values, advancing only on the pixel tick.
  always_comb begin
    hcount_next_s = hcount_r;
    vcount_next_s = vcount_r;
    if (pix_en_r) begin
      if (hcount_r == CNT_W'(H_TOTAL - 1)) begin
        hcount_next_s = {CNT_W{1'b0}};
        if (vcount_r == CNT_W'(V_TOTAL - 1)) begin
          vcount_next_s = {CNT_W{1'b0}};
        end else begin
          vcount_next_s = vcount_r + CNT_W'(1);
        end
      end else begin
        hcount_next_s = hcount_r + CNT_W'(1);
      end
    end else begin
      hcount_next_s = hcount_r;
      vcount_next_s = vcount_r;
    end
  end

  // Position counter registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      hcount_r <= {CNT_W{1'b0}};
      vcount_r <= {CNT_W{1'b0}};
    end else begin
      hcount_r <= hcount_next_s;
      vcount_r <= vcount_next_s;
    end
  end

  // Raw (undelayed) sync, active-video and start-of-frame decode.
  always_comb begin
    hs_s  = (int'(hcount_r) >= HS_START) && (int'(hcount_r) < HS_END);
    vs_s  = (int'(vcount_r) >= VS_START) && (int'(vcount_r) < VS_END);
    act_s = (int'(hcount_r) < H_ACTIVE) && (int'(vcount_r) < V_ACTIVE);
    sof_s = (hcount_r == {CNT_W{1'b0}}) && (vcount_r == {CNT_W{1'b0}});
  end

`ifdef VGA_TEST_PATTERN_EN
  // The mode seen by a pixel: the new request applies from pixel (0,0) on, so a frame never mixes modes.
  always_comb begin
    if (sof_s) begin
      mode_s = test_mode;
    end else begin
      mode_s = mode_r;
    end
  end

  // Latch the requested mode only at the start-of-frame tick.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      mode_r <= 1'b0;
    end else if (pix_en_r && sof_s) begin
      mode_r <= test_mode;
    end else begin
      mode_r <= mode_r;
    end
  end

  assign raw_s    = {hcount_r, mode_s, hs_s, vs_s, act_s, sof_s};
  assign mode_d   = dly_s[4];
  assign hcount_d = dly_s[5 +: CNT_W];
`else
  assign raw_s    = {hs_s, vs_s, act_s, sof_s};
`endif

  assign hs_d  = dly_s[3];
  assign vs_d  = dly_s[2];
  assign act_d = dly_s[1];
  assign sof_d = dly_s[0];

  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign dly_s = raw_s;
    end else begin : g_pipe
      logic [DW-1:0] stage_r [PIPE_LAT];

      // Alignment shift line: one stage per pixel tick, cleared to inactive.
      always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            stage_r[i] <= {DW{1'b0}};
          end
        end else if (pix_en_r) begin
          stage_r[0] <= raw_s;
          for (int i = 1; i < PIPE_LAT; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dly_s = stage_r[PIPE_LAT-1];
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  assign bar_prod_s = {hcount_d, 3'b000};
  assign bar_idx_s  = 3'(bar_prod_s / (CNT_W+3)'(H_ACTIVE));
`endif

  // Colour selection: blank forces black, otherwise expanded source (or bars).
  always_comb begin
    red_s   = 8'h00;
    green_s = 8'h00;
    blue_s  = 8'h00;
    if (act_d) begin
`ifdef VGA_TEST_PATTERN_EN
      if (mode_d) begin
        red_s   = {8{bar_idx_s[2]}};
        green_s = {8{bar_idx_s[1]}};
        blue_s  = {8{bar_idx_s[0]}};
      end else begin
        red_s   = expand(pix_rgb[3*IN_BITS-1 -: IN_BITS]);
        green_s = expand(pix_rgb[2*IN_BITS-1 -: IN_BITS]);
        blue_s  = expand(pix_rgb[IN_BITS-1:0]);
      end
`else
      red_s   = expand(pix_rgb[3*IN_BITS-1 -: IN_BITS]);
      green_s = expand(pix_rgb[2*IN_BITS-1 -: IN_BITS]);
      blue_s  = expand(pix_rgb[IN_BITS-1:0]);
`endif
    end else begin
      red_s   = 8'h00;
      green_s = 8'h00;
      blue_s  = 8'h00;
    end
  end

  // Output register: updates on the pixel tick and holds in between; frame_start is a one-clk pulse.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      hsync_r       <= ~H_POL;
      vsync_r       <= ~V_POL;
      bright_r      <= 1'b0;
      frame_start_r <= 1'b0;
      red_r         <= 8'h00;
      green_r       <= 8'h00;
      blue_r        <= 8'h00;
    end else begin
      frame_start_r <= pix_en_r & sof_d;
      if (pix_en_r) begin
        hsync_r  <= hs_d ? H_POL : ~H_POL;
        vsync_r  <= vs_d ? V_POL : ~V_POL;
        bright_r <= act_d;
        red_r    <= red_s;
        green_r  <= green_s;
        blue_r   <= blue_s;
      end
    end
  end

  assign pix_en      = pix_en_r;
  assign vga_clk     = vga_clk_r;
  assign hcount      = hcount_r;
  assign vcount      = vcount_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign bright      = bright_r;
  assign frame_start = frame_start_r;
  assign Red         = red_r;
  assign Green       = green_r;
  assign Blue        = blue_r;

endmodule
